// File: rtl/ql_bus_pkg.sv
// Shared types and constants for the QL 8-bit RAM bus initiator.
package ql_bus_pkg;

  // Byte sequencer states
  typedef enum logic [2:0] {
    StIdle,
    StReqHi,
    StReqLo,
    StDone,
    StRelease
  } ql_bus_seq_state_t;

  // Byte-address LSB for each CPU lane: upper lane is the even byte
  localparam logic LANE_HI = 1'b0;
  localparam logic LANE_LO = 1'b1;

  // Value returned for a lane that was not read (or that timed out)
  localparam logic [7:0] RD_IDLE_BYTE = 8'hFF;

endpackage

// File: rtl/ql_bus_timeout.sv
// Per-byte acknowledge watchdog for the QL bus sequencer.
// Only instantiated when QL_BUS_TIMEOUT_EN is defined.
module ql_bus_timeout #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LastCnt = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q, cnt_d;

  // Expires in the TIMEOUT-th enabled cycle since the last clear
  always_comb begin
    expired = enable && (cnt_q == LastCnt);
    cnt_d   = cnt_q;
    if (clear || expired) begin
      cnt_d = 8'd0;
    end else if (enable) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Counter register
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ql_bus_byte_sequencer.sv
// Initiator side of the QL 8-bit RAM bus: splits a 68000-style 16-bit cycle into one or
// two byte requests (even byte first), assembles read data and returns cpu_dtack.
// Optional per-byte ack timeout enabled by defining QL_BUS_TIMEOUT_EN.
module ql_bus_byte_sequencer
  import ql_bus_pkg::*;
#(
  parameter int unsigned ADDR_W  = 24,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              cpu_as,
  input  logic              cpu_rw,
  input  logic              cpu_uds,
  input  logic              cpu_lds,
  input  logic [ADDR_W-2:0] cpu_addr,
  input  logic [15:0]       cpu_dout,
  output logic [15:0]       cpu_din,
  output logic              cpu_dtack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              bus_err
);

  ql_bus_seq_state_t state_q, state_d;

  logic              rd_q, rd_d;
  logic              lds_q, lds_d;
  logic [ADDR_W-2:0] addr_q, addr_d;
  logic [15:0]       dout_q, dout_d;
  logic [15:0]       din_q, din_d;
  // One dead cycle between the even and odd request so the two never merge
  logic              gap_q, gap_d;

  logic              in_req;
  logic              lane_lo;
  logic              timeout_hit;
  logic              byte_done;
  logic [7:0]        byte_data;

  assign in_req    = (state_q == StReqHi) || (state_q == StReqLo);
  assign lane_lo   = (state_q == StReqLo);
  assign mem_req   = in_req && !gap_q;
  assign byte_done = mem_req && (mem_ack || timeout_hit);
  assign byte_data = mem_ack ? mem_rdata : RD_IDLE_BYTE;

`ifdef QL_BUS_TIMEOUT_EN
  logic to_expired;

  ql_bus_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk_sys(clk_sys),
    .reset  (reset),
    .clear  (!mem_req || mem_ack),
    .enable (mem_req),
    .expired(to_expired)
  );

  // A real ack in the expiry cycle wins over the timeout
  assign timeout_hit = to_expired && !mem_ack;
  assign bus_err     = mem_req && timeout_hit;
`else
  logic unused_timeout;
  assign unused_timeout = ^8'(TIMEOUT);
  assign timeout_hit    = 1'b0;
  assign bus_err        = 1'b0;
`endif

  // Memory-side outputs are zero whenever no request is on the bus
  always_comb begin
    mem_we    = mem_req && !rd_q;
    mem_addr  = '0;
    mem_wdata = 8'd0;
    if (mem_req) begin
      mem_addr = {addr_q, lane_lo ? LANE_LO : LANE_HI};
      if (!rd_q) begin
        mem_wdata = lane_lo ? dout_q[7:0] : dout_q[15:8];
      end
    end
    cpu_din   = din_q;
    cpu_dtack = (state_q == StDone);
    busy      = (state_q != StIdle);
  end

  // Next-state: latch the CPU cycle, step through the byte requests, handshake dtack
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    lds_d   = lds_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    din_d   = din_q;
    gap_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cpu_as && (cpu_uds || cpu_lds)) begin
          rd_d   = cpu_rw;
          lds_d  = cpu_lds;
          addr_d = cpu_addr;
          dout_d = cpu_dout;
          if (cpu_rw) begin
            din_d = {RD_IDLE_BYTE, RD_IDLE_BYTE};
          end
          state_d = cpu_uds ? StReqHi : StReqLo;
        end
      end
      StReqHi: begin
        if (byte_done) begin
          if (rd_q) begin
            din_d[15:8] = byte_data;
          end
          if (!cpu_as) begin
            state_d = StRelease;
          end else if (lds_q) begin
            state_d = StReqLo;
            gap_d   = 1'b1;
          end else begin
            state_d = StDone;
          end
        end
      end
      StReqLo: begin
        if (byte_done) begin
          if (rd_q) begin
            din_d[7:0] = byte_data;
          end
          state_d = cpu_as ? StDone : StRelease;
        end
      end
      StDone: begin
        if (!cpu_as) begin
          state_d = StRelease;
        end
      end
      StRelease: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and latched-cycle registers
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= StIdle;
      rd_q    <= 1'b0;
      lds_q   <= 1'b0;
      addr_q  <= '0;
      dout_q  <= 16'd0;
      din_q   <= {RD_IDLE_BYTE, RD_IDLE_BYTE};
      gap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      lds_q   <= lds_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      din_q   <= din_d;
      gap_q   <= gap_d;
    end
  end

endmodule

// File: tb/tb_ql_bus_byte_sequencer.sv
// Directed bench for ql_bus_byte_sequencer. Timeout scenario runs when QL_BUS_TIMEOUT_EN is set.
module tb_ql_bus_byte_sequencer;

  localparam int unsigned ADDR_W = 24;

  logic              clk_sys = 1'b0;
  logic              reset;
  logic              cpu_as, cpu_rw, cpu_uds, cpu_lds;
  logic [ADDR_W-2:0] cpu_addr;
  logic [15:0]       cpu_dout;
  logic [15:0]       cpu_din;
  logic              cpu_dtack;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata, mem_rdata;
  logic              mem_ack;
  logic              busy, bus_err;

  int checks = 0;
  int errors = 0;

  ql_bus_byte_sequencer #(
    .ADDR_W (ADDR_W),
    .TIMEOUT(10)
  ) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .cpu_as   (cpu_as),
    .cpu_rw   (cpu_rw),
    .cpu_uds  (cpu_uds),
    .cpu_lds  (cpu_lds),
    .cpu_addr (cpu_addr),
    .cpu_dout (cpu_dout),
    .cpu_din  (cpu_din),
    .cpu_dtack(cpu_dtack),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .busy     (busy),
    .bus_err  (bus_err)
  );

  always #5 clk_sys = ~clk_sys;

  // Advance one clock; outputs are then settled and inputs may be changed for the next edge
  task automatic cyc();
    @(posedge clk_sys);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int pulses;
    int first_err;
    bit got_dtack;

    reset = 1'b1; cpu_as = 1'b0; cpu_rw = 1'b0; cpu_uds = 1'b0; cpu_lds = 1'b0;
    cpu_addr = '0; cpu_dout = 16'd0; mem_rdata = 8'd0; mem_ack = 1'b0;
    cyc(); cyc();
    chk("rst_req", mem_req, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_dtack", cpu_dtack, 1'b0);
    chk("rst_din", cpu_din, 16'hFFFF);
    chk("rst_err", bus_err, 1'b0);
    chk("rst_addr", mem_addr, 24'h0);
    reset = 1'b0;
    cyc();

    // 16-bit read of word 0x01000, ack on the third request cycle of each byte
    cpu_as = 1'b1; cpu_rw = 1'b1; cpu_uds = 1'b1; cpu_lds = 1'b1; cpu_addr = 23'h01000;
    cyc();
    chk("rd16_req_hi", mem_req, 1'b1);
    chk("rd16_addr_hi", mem_addr, 24'h002000);
    chk("rd16_we", mem_we, 1'b0);
    chk("rd16_busy", busy, 1'b1);
    cyc(); cyc();
    mem_ack = 1'b1; mem_rdata = 8'hA5;
    cyc();
    mem_ack = 1'b0; mem_rdata = 8'h00;
    chk("rd16_gap", mem_req, 1'b0);
    chk("rd16_nodtack", cpu_dtack, 1'b0);
    cyc();
    chk("rd16_req_lo", mem_req, 1'b1);
    chk("rd16_addr_lo", mem_addr, 24'h002001);
    cyc(); cyc();
    mem_ack = 1'b1; mem_rdata = 8'h3C;
    cyc();
    mem_ack = 1'b0; mem_rdata = 8'h00;
    chk("rd16_dtack", cpu_dtack, 1'b1);
    chk("rd16_din", cpu_din, 16'hA53C);
    chk("rd16_req_off", mem_req, 1'b0);
    cyc(); cyc();
    chk("rd16_dtack_held", cpu_dtack, 1'b1);
    cpu_as = 1'b0;
    cyc();
    chk("rd16_release_dtack", cpu_dtack, 1'b0);
    chk("rd16_release_busy", busy, 1'b1);
    cyc();
    chk("rd16_idle", busy, 1'b0);

    // Strobe with no lane selected, plus a stray ack, must not start a cycle
    cpu_as = 1'b1; cpu_uds = 1'b0; cpu_lds = 1'b0; mem_ack = 1'b1; mem_rdata = 8'h99;
    cyc();
    chk("nolane_busy", busy, 1'b0);
    chk("nolane_req", mem_req, 1'b0);
    cyc();
    chk("stray_ack_din", cpu_din, 16'hA53C);
    cpu_as = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00;
    cyc();

    // Byte write, lower lane only
    cpu_as = 1'b1; cpu_rw = 1'b0; cpu_uds = 1'b0; cpu_lds = 1'b1;
    cpu_addr = 23'h00800; cpu_dout = 16'h0077;
    cyc();
    cpu_dout = 16'h1234;
    chk("wr_req", mem_req, 1'b1);
    chk("wr_addr", mem_addr, 24'h001001);
    chk("wr_we", mem_we, 1'b1);
    chk("wr_wdata", mem_wdata, 8'h77);
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    chk("wr_dtack", cpu_dtack, 1'b1);
    chk("wr_din_kept", cpu_din, 16'hA53C);
    chk("wr_single_req", mem_req, 1'b0);
    cpu_as = 1'b0;
    cyc(); cyc();

    // Byte read, upper lane only
    cpu_as = 1'b1; cpu_rw = 1'b1; cpu_uds = 1'b1; cpu_lds = 1'b0; cpu_addr = 23'h00123;
    cyc();
    chk("rdhi_addr", mem_addr, 24'h000246);
    mem_ack = 1'b1; mem_rdata = 8'h5A;
    cyc();
    mem_ack = 1'b0; mem_rdata = 8'h00;
    chk("rdhi_dtack", cpu_dtack, 1'b1);
    chk("rdhi_din", cpu_din, 16'h5AFF);
    cpu_as = 1'b0;
    cyc(); cyc();

    // Strobe drops during the even byte of a 16-bit read
    cpu_as = 1'b1; cpu_rw = 1'b1; cpu_uds = 1'b1; cpu_lds = 1'b1; cpu_addr = 23'h00010;
    cyc();
    chk("abort_req", mem_req, 1'b1);
    cpu_as = 1'b0;
    cyc();
    chk("abort_req_kept", mem_req, 1'b1);
    mem_ack = 1'b1; mem_rdata = 8'h11;
    cyc();
    mem_ack = 1'b0; mem_rdata = 8'h00;
    chk("abort_release_busy", busy, 1'b1);
    chk("abort_release_dtack", cpu_dtack, 1'b0);
    chk("abort_release_req", mem_req, 1'b0);
    cyc();
    chk("abort_idle", busy, 1'b0);
    chk("abort_no_lo", mem_req, 1'b0);
    chk("abort_no_dtack", cpu_dtack, 1'b0);

    // Reset while the odd byte is outstanding
    cpu_as = 1'b1; cpu_rw = 1'b1; cpu_uds = 1'b0; cpu_lds = 1'b1; cpu_addr = 23'h00200;
    cyc();
    chk("rstmid_req", mem_req, 1'b1);
    reset = 1'b1;
    cyc();
    chk("rstmid_req_off", mem_req, 1'b0);
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_dtack", cpu_dtack, 1'b0);
    chk("rstmid_din", cpu_din, 16'hFFFF);
    reset = 1'b0; cpu_as = 1'b0;
    cyc();

`ifdef QL_BUS_TIMEOUT_EN
    // No ack at all on a 16-bit read: each byte times out after 10 request cycles
    pulses = 0; first_err = -1; got_dtack = 1'b0;
    cpu_as = 1'b1; cpu_rw = 1'b1; cpu_uds = 1'b1; cpu_lds = 1'b1; cpu_addr = 23'h00400;
    cyc();
    for (int i = 1; i <= 60; i++) begin
      if (bus_err) begin
        pulses++;
        if (first_err < 0) first_err = i;
      end
      if (cpu_dtack) begin
        got_dtack = 1'b1;
        break;
      end
      cyc();
    end
    chk("to_dtack", got_dtack, 1'b1);
    chk("to_pulses", pulses, 2);
    chk("to_first_cycle", first_err, 10);
    chk("to_din", cpu_din, 16'hFFFF);
    cpu_as = 1'b0;
    cyc(); cyc();
`else
    pulses = 0; first_err = 0; got_dtack = 1'b0;
    chk("no_timeout_err", bus_err, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
